mux81_rr_arbiter: RTL
=====================

// Module: mux81_rr_arbiter
// PURPOSE
//   Round-robin arbiter for the shared 8:1 mux path (mux81_strc). Up to 8 requesters
//   compete for the mux. The block grants one requester at a time and drives the
//   mux select lines {s2,s1,s0} from its registered sel output.
//   A hold-time limit stops any requester from owning the path indefinitely.
// PARAMETERS
//   N_REQ     8    number of requesters; fixed to the mux input count
//   SEL_W     3    select width; must equal clog2(N_REQ)
//   MAX_HOLD  16   max consecutive grant cycles per requester (>=2)
//   HOLD_W    5    hold-counter width; must satisfy 2**HOLD_W > MAX_HOLD
// PORTS
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      reset, asynchronous, active-low
//   en        in   1      1 = new grants may be issued; 0 = current grant runs to release
//   req       in   N_REQ  request vector; req[i] held high while i wants the mux
//   gnt       out  N_REQ  one-hot grant, registered; all zero when idle
//   sel       out  SEL_W  index of granted requester; drives {s2,s1,s0}
//   gnt_vld   out  1      1 = gnt/sel valid and mux output owned
//   timeout   out  1      1-cycle pulse: previous grant was force-released at MAX_HOLD
// BEHAVIOUR
//   Reset (async assert, sync deassert at the clk edge):
//     - state=IDLE, gnt=0, sel=0, gnt_vld=0, timeout=0, hold_cnt=0.
//     - last pointer = N_REQ-1, so req[0] has the highest priority first.
//   Picker: search req circularly from last+1 upward; the first set bit wins.
//   States IDLE, GRANT:
//     - IDLE: if en and |req, register the winner (gnt one-hot, sel=index,
//       gnt_vld=1, hold_cnt=0) and go to GRANT. Latency req->gnt is 1 cycle.
//     - GRANT: hold_cnt increments each cycle. A release occurs when
//       req[sel]==0 OR hold_cnt==MAX_HOLD-1.
//     - On release: last=sel.
//       - If en and any req is eligible, the new winner is granted on the next edge
//         (back-to-back, no bubble). Otherwise go to IDLE with gnt=0, gnt_vld=0.
//       - sel keeps its last value while idle.
//   Eligibility on release:
//     - After a req drop, the dropped requester is not set, so it cannot win.
//     - After a timeout, the current requester is last in search order. It is
//       re-granted (fresh hold_cnt) only if no other request is set.
//   timeout:
//     - Goes high in the cycle after a forced release; high for exactly 1 cycle.
//     - Does not pulse for a voluntary release.
//     - If the drop and the limit hit in the same cycle, it counts as voluntary (timeout=0).
//   en=0:
//     - An ongoing grant is unaffected until it releases.
//     - No new grant is issued while en=0; requests stay pending. There is no queueing.
//   Requests arriving in the same cycle as a release are considered immediately.
//   Grant invariant: gnt is always one-hot or zero, and gnt==(1<<sel) whenever gnt_vld=1.
//   Mid-grant reset: all outputs clear immediately, no waiting for the clock.
//   Widths: hold_cnt saturates at MAX_HOLD-1; the pointer increments mod N_REQ.
// STRUCTURE
//   Package mux_arb_pkg:
//     - N_REQ and SEL_W constants.
//     - State enum {ARB_IDLE, ARB_GRANT}.
//   Sub-module rr_pick (combinational):
//     - Inputs req, last. Outputs any, idx[SEL_W-1:0].
//     - Implemented as a rotate, fixed-priority encode, un-rotate.
//   Top level holds the FSM, hold counter, pointer and output registers.
// TESTING
//   1 Reset: rst_n=0 with req=8'hFF -> gnt=0, sel=0, gnt_vld=0, timeout=0.
//     Release at cycle 0; req=8'h01 at cycle 1 -> gnt=8'h01 at cycle 2.
//   2 Single req: req=8'h20 at cycle 0 -> cycle 1 gnt=8'h20, sel=5, gnt_vld=1.
//     req=0 at cycle 4 -> cycle 5 gnt=0, gnt_vld=0, timeout=0.
//   3 Saturation: MAX_HOLD=4, req=8'hFF held -> sel steps 0,1,..7,0, each held 4 cycles.
//     No idle cycles; timeout pulses once per handover.
//   4 Handover: req=8'h48, sel=3 granted -> drop req[3] -> next cycle sel=6, gnt=8'h40.
//     Then req=8'h08 -> after req[6] drops, sel=3.
//   5 Timeout with no contention: MAX_HOLD=4, req=8'h04 held -> timeout pulses.
//     sel stays 2, gnt_vld stays 1, and the grant re-arms every 4 cycles.
//   6 Enable gating: en=0, req=8'h10 -> no grant for 10 cycles.
//     en=1 -> gnt=8'h10 one cycle later. Pulse rst_n mid-grant -> gnt=0 asynchronously.

Source files
------------

// File: rtl/mux81_rr_arbiter_pkg.sv
// Shared constants and types for the 8:1 mux round-robin arbiter.
//   N_REQ   : requester count (equals the mux input count)
//   SEL_W   : select width driving {s2,s1,s0}
//   arb_state_e : arbiter FSM states
//   grant_t : registered grant payload (one-hot grant, index, valid)
package mux_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             vld;
  } grant_t;

  // Index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux81_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the mux arbiter.
//   en      : new grants allowed
//   req     : request vector, one bit per requester
//   gnt     : one-hot grant
//   sel     : granted index, drives the mux selects
//   gnt_vld : gnt/sel valid
//   timeout : one-cycle pulse after a forced release
// master = requester side, slave = arbiter side.
interface mux81_rr_arbiter_if;

  logic                              en;
  logic [mux_arb_pkg::N_REQ-1:0]     req;
  logic [mux_arb_pkg::N_REQ-1:0]     gnt;
  logic [mux_arb_pkg::SEL_W-1:0]     sel;
  logic                              gnt_vld;
  logic                              timeout;

  modport master (
    output en, req,
    input  gnt, sel, gnt_vld, timeout
  );

  modport slave (
    input  en, req,
    output gnt, sel, gnt_vld, timeout
  );

endinterface

// File: rtl/mux81_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector
//   last : most recently served index; search starts at last+1
//   any  : at least one request set
//   idx  : winning index (valid when any=1)
// Rotate so last+1 sits at bit 0, take the lowest set bit, rotate the
// offset back. The previous owner ends up last in search order.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] pos;
  logic [SEL_W-1:0] off;
  logic [N_REQ-1:0] rot;

  always_comb begin
    start = last + SEL_W'(1);
    pos   = '0;
    rot   = '0;
    off   = '0;
    // Rotate: rot[k] = req[(last+1+k) mod N_REQ]; SEL_W arithmetic wraps.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos    = start + SEL_W'(k);
      rot[k] = req[pos];
    end
    // Fixed-priority encode, lowest bit wins (descending loop, last write wins).
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
    any = |req;
    idx = start + off;
  end

endmodule

// File: rtl/mux81_rr_arbiter.sv
// Round-robin arbiter owning the shared 8:1 mux path.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of mux81_rr_arbiter_if (en/req in,
//                gnt/sel/gnt_vld/timeout out, all registered)
// Parameters:
//   MAX_HOLD : max consecutive grant cycles per requester (>=2)
//   HOLD_W   : hold counter width, 2**HOLD_W > MAX_HOLD
module mux81_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux81_rr_arbiter_if.slave    bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  grant_t           grant_q, grant_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             timeout_q, timeout_d;

  logic [SEL_W-1:0] pick_last;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             cur_req;
  logic             at_limit;
  logic             release_c;
  logic             forced_c;

  // While granting, search from the current owner so it is eligible last.
  assign pick_last = (state_q == ARB_GRANT) ? grant_q.sel : last_q;

  rr_pick u_pick (
    .req  (bus.req),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign cur_req   = bus.req[grant_q.sel];
  assign at_limit  = (hold_q == HOLD_LIM);
  assign release_c = !cur_req || at_limit;
  // A drop coinciding with the limit is treated as voluntary.
  assign forced_c  = cur_req && at_limit;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    hold_d    = hold_q;
    last_d    = last_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (bus.en && pick_any) begin
          grant_d.gnt = onehot(pick_idx);
          grant_d.sel = pick_idx;
          grant_d.vld = 1'b1;
          hold_d      = '0;
          state_d     = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (release_c) begin
          last_d    = grant_q.sel;
          timeout_d = forced_c;
          if (bus.en && pick_any) begin
            // Back-to-back handover, fresh hold count.
            grant_d.gnt = onehot(pick_idx);
            grant_d.sel = pick_idx;
            grant_d.vld = 1'b1;
            hold_d      = '0;
          end else begin
            // sel keeps its last value while idle.
            grant_d.gnt = '0;
            grant_d.vld = 1'b0;
            hold_d      = '0;
            state_d     = ARB_IDLE;
          end
        end else if (!at_limit) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      hold_q    <= '0;
      last_q    <= SEL_W'(N_REQ - 1);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = grant_q.gnt;
  assign bus.sel     = grant_q.sel;
  assign bus.gnt_vld = grant_q.vld;
  assign bus.timeout = timeout_q;

endmodule
